// File: rtl/arb_pkg.sv
// Shared types and constants for the arbiter grant sink.
package arb_pkg;

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} sink_state_t;

    localparam int CNT_W = 16;

endpackage

// File: rtl/arb_sync_fifo.sv
// Synchronous show-ahead FIFO with extended-pointer full/empty detection.
module arb_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Head reads as zero when empty so stale entries never leak out.
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/arb_grant_sink.sv
// Four-phase grant consumer: synchronises req, acks, and queues {sel,data} in a FIFO.
// Optional per-channel grant counters are built when ARB_GRANT_CNT_EN is defined.
module arb_grant_sink
    import arb_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_in,
    input  logic                     sel_in,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     ack_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sel,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   fifo_count
`ifdef ARB_GRANT_CNT_EN
    ,
    input  logic                     cnt_clr,
    output logic [CNT_W-1:0]         grant_cnt0,
    output logic [CNT_W-1:0]         grant_cnt1
`endif
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    sink_state_t            state;
    logic                   push;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_W:0]        head;

    assign req_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
    end

    // A full FIFO simply withholds the ack; the request is retried every cycle.
    assign push = (state == IDLE) && req_s && !fifo_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ack_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack_out <= 1'b0;
                    if (push) begin
                        state   <= HOLD;
                        ack_out <= 1'b1;
                    end
                end
                HOLD: begin
                    if (!req_s) begin
                        state   <= IDLE;
                        ack_out <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ack_out <= 1'b0;
                end
            endcase
        end
    end

    arb_sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({sel_in, data_in}),
        .pop       (out_ready),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign out_sel   = head[DATA_W];
    assign out_data  = head[DATA_W-1:0];

`ifdef ARB_GRANT_CNT_EN
    // Clear has priority over a coincident push; counters stick at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (cnt_clr) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (push) begin
            if (!sel_in && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + 1'b1;
            if ( sel_in && (grant_cnt1 != '1)) grant_cnt1 <= grant_cnt1 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_arb_grant_sink.sv
// Self-checking bench for arb_grant_sink: directed protocol scenarios plus randomized traffic.
module tb_arb_grant_sink;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_in;
    logic       sel_in;
    logic [7:0] data_in;
    logic       ack_out;
    logic       out_valid;
    logic       out_ready;
    logic       out_sel;
    logic [7:0] out_data;
    logic [2:0] fifo_count;
`ifdef ARB_GRANT_CNT_EN
    logic        cnt_clr;
    logic [15:0] grant_cnt0;
    logic [15:0] grant_cnt1;
`endif

    int total = 0;
    int bad   = 0;

    logic [8:0] exp_q[$];
    logic       ack_prev;
    logic       cur_sel;
    logic [7:0] cur_data;
    logic       rand_ready;
    int         exp_cnt0;
    int         exp_cnt1;

    arb_grant_sink #(.DATA_W(8), .DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_in     (req_in),
        .sel_in     (sel_in),
        .data_in    (data_in),
        .ack_out    (ack_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sel    (out_sel),
        .out_data   (out_data),
        .fifo_count (fifo_count)
`ifdef ARB_GRANT_CNT_EN
        ,
        .cnt_clr    (cnt_clr),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // One clock cycle, called and returning at a negedge. Inputs set by the caller apply
    // to the coming posedge; the scoreboard is updated from what the cycle produced.
    task automatic step();
        logic       pop_pending;
        logic [2:0] exp_count;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        pop_pending = out_valid && out_ready;
        if (pop_pending) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_empty_model: out_valid=1 but reference queue is empty");
                pop_pending = 1'b0;
            end else if ({out_sel, out_data} !== exp_q[0]) begin
                bad++;
                $display("FAIL pop_head: got sel=%0d data=%h want sel=%0d data=%h",
                         out_sel, out_data, exp_q[0][8], exp_q[0][7:0]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (pop_pending) void'(exp_q.pop_front());
        if (ack_out && !ack_prev) begin
            exp_q.push_back({cur_sel, cur_data});
            if (cur_sel) exp_cnt1++; else exp_cnt0++;
        end
        ack_prev  = ack_out;
        exp_count = 3'(exp_q.size());
        total++;
        if (fifo_count !== exp_count) begin
            bad++;
            $display("FAIL fifo_count: got %0d want %0d", fifo_count, exp_count);
        end
        total++;
        if (out_valid !== (exp_q.size() != 0)) begin
            bad++;
            $display("FAIL out_valid: got %0b want %0b", out_valid, exp_q.size() != 0);
        end
    endtask

    task automatic start_req(input logic sel, input logic [7:0] data);
        cur_sel  = sel;
        cur_data = data;
        sel_in   = sel;
        data_in  = data;
        req_in   = 1'b1;
    endtask

    // Full four-phase handshake driven as the arbiter would, with bounded waits.
    task automatic hs(input logic sel, input logic [7:0] data);
        int n;
        start_req(sel, data);
        n = 0;
        while (!ack_out && n < 40) begin step(); n++; end
        total++;
        if (!ack_out) begin bad++; $display("FAIL hs_ack_rise: ack=%0b want 1 within 40 cycles", ack_out); end
        req_in = 1'b0;
        n = 0;
        while (ack_out && n < 40) begin step(); n++; end
        total++;
        if (ack_out) begin bad++; $display("FAIL hs_ack_fall: ack=%0b want 0 within 40 cycles", ack_out); end
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin step(); n++; end
        step();
        total++;
        if (fifo_count !== 3'd0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: fifo_count=%0d model=%0d want 0", fifo_count, exp_q.size());
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_in = 1'b0; sel_in = 1'b0; data_in = '0; out_ready = 1'b0;
        #1;
        total++;
        if (ack_out !== 1'b0 || out_valid !== 1'b0 || fifo_count !== 3'd0 ||
            out_sel !== 1'b0 || out_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_state: ack=%0b valid=%0b count=%0d sel=%0b data=%h want all 0",
                     ack_out, out_valid, fifo_count, out_sel, out_data);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_first_grant();
        start_req(1'b1, 8'hA5);
        for (int i = 1; i <= 3; i++) begin
            step();
            total++;
            if (ack_out !== (i == 3)) begin
                bad++;
                $display("FAIL rise_latency edge%0d: ack=%0b want %0b", i, ack_out, i == 3);
            end
        end
        total++;
        if (out_valid !== 1'b1 || out_sel !== 1'b1 || out_data !== 8'hA5 || fifo_count !== 3'd1) begin
            bad++;
            $display("FAIL first_capture: valid=%0b sel=%0b data=%h count=%0d want 1 1 a5 1",
                     out_valid, out_sel, out_data, fifo_count);
        end
    endtask

    task automatic test_release();
        req_in = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            total++;
            if (ack_out !== (i != 3)) begin
                bad++;
                $display("FAIL fall_latency edge%0d: ack=%0b want %0b", i, ack_out, i != 3);
            end
        end
        repeat (4) step();
        total++;
        if (fifo_count !== 3'd1) begin
            bad++;
            $display("FAIL no_second_push: fifo_count=%0d want 1", fifo_count);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        hs(1'b0, 8'h11);
        hs(1'b1, 8'h22);
        repeat (3) step();
        total++;
        if (fifo_count !== 3'd0) begin
            bad++;
            $display("FAIL b2b_empty: fifo_count=%0d want 0", fifo_count);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) hs(1'(i), 8'h40 + 8'(i));
        total++;
        if (fifo_count !== 3'd4) begin bad++; $display("FAIL full_count: fifo_count=%0d want 4", fifo_count); end
        start_req(1'b1, 8'h55);
        repeat (8) begin
            step();
            total++;
            if (ack_out !== 1'b0) begin bad++; $display("FAIL backpressure: ack=%0b want 0", ack_out); end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++;
        if (ack_out !== 1'b0 || fifo_count !== 3'd3) begin
            bad++;
            $display("FAIL pop_edge: ack=%0b count=%0d want 0 3", ack_out, fifo_count);
        end
        step();
        total++;
        if (ack_out !== 1'b1 || fifo_count !== 3'd4) begin
            bad++;
            $display("FAIL retry_push: ack=%0b count=%0d want 1 4", ack_out, fifo_count);
        end
        req_in = 1'b0;
        repeat (4) step();
        drain();
    endtask

    task automatic test_reset_mid_handshake();
        int n;
        start_req(1'b0, 8'h3C);
        n = 0;
        while (!ack_out && n < 40) begin step(); n++; end
        #2 rst = 1'b1;
        #1;
        total++;
        if (ack_out !== 1'b0 || fifo_count !== 3'd0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: ack=%0b count=%0d valid=%0b want 0 0 0", ack_out, fifo_count, out_valid);
        end
        exp_q.delete();
        ack_prev = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            total++;
            if (ack_out !== (i == 3)) begin
                bad++;
                $display("FAIL recapture edge%0d: ack=%0b want %0b", i, ack_out, i == 3);
            end
        end
        req_in = 1'b0;
        repeat (4) step();
        drain();
    endtask

    task automatic test_random();
        rand_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            hs(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 2)) step();
        end
        rand_ready = 1'b0;
        drain();
    endtask

`ifdef ARB_GRANT_CNT_EN
    task automatic test_counters();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        out_ready = 1'b1;
        hs(1'b0, 8'h01); hs(1'b1, 8'h02); hs(1'b0, 8'h03); hs(1'b1, 8'h04); hs(1'b0, 8'h05);
        total++;
        if (grant_cnt0 !== 16'(exp_cnt0) || grant_cnt1 !== 16'(exp_cnt1) || exp_cnt0 != 3 || exp_cnt1 != 2) begin
            bad++;
            $display("FAIL grant_cnt: got %0d/%0d want 3/2", grant_cnt0, grant_cnt1);
        end
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        total++;
        if (grant_cnt0 !== 16'd0 || grant_cnt1 !== 16'd0) begin
            bad++;
            $display("FAIL cnt_clr: got %0d/%0d want 0/0", grant_cnt0, grant_cnt1);
        end
        drain();
    endtask
`endif

    initial begin
        rand_ready = 1'b0;
        ack_prev   = 1'b0;
        cur_sel    = 1'b0;
        cur_data   = '0;
        exp_cnt0   = 0;
        exp_cnt1   = 0;
`ifdef ARB_GRANT_CNT_EN
        cnt_clr    = 1'b0;
`endif
        test_reset();
        test_first_grant();
        test_release();
        test_back_to_back();
        test_full();
        test_reset_mid_handshake();
        test_random();
`ifdef ARB_GRANT_CNT_EN
        test_counters();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arb_grant_sink.md
Name: arb_grant_sink

Overview:
- Clocked consumer placed directly downstream of the 2-input four-phase arbiter.
- Samples the arbiter's `req_out` through a synchroniser and captures the bundled `sel` and payload.
- Returns `ack_out` to the arbiter using the four-phase protocol.
- Queues each granted transfer, tagged with its source channel, in a small FIFO that synchronous logic drains with a valid/ready interface.

Parameters:
- DATA_W, 8, width of payload bundled with the request.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- SYNC_STAGES, 2, flops in the req synchroniser; minimum 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset; clears all state.
- req_in  in  1  request from arbiter (`req_out`); asynchronous, four-phase.
- sel_in  in  1  arbiter selected channel; bundled data, stable while req_in=1.
- data_in  in  DATA_W  payload of selected channel; bundled, stable while req_in=1.
- ack_out  out  1  acknowledge to arbiter (`ack_out`); driven from a flop.
- out_valid  out  1  FIFO head entry available.
- out_ready  in  1  consumer accepts head this cycle.
- out_sel  out  1  channel tag of head entry.
- out_data  out  DATA_W  payload of head entry.
- fifo_count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (asynchronous, active-high, one clock, reset fixed as stated):
  - ack_out=0, out_valid=0, fifo_count=0, FSM=IDLE, synchroniser flops=0.
  - out_sel and out_data read as 0 while the FIFO is empty.
- Synchroniser: req_s = req_in delayed through SYNC_STAGES flops. The FSM uses only req_s.
- FSM states:
  - IDLE: ack_out=0. If req_s=1 and the FIFO is not full, push {sel_in,data_in}, set ack_out<=1 and go to HOLD. If req_s=1 and the FIFO is full, stay in IDLE with ack withheld (backpressure) and retry every cycle.
  - HOLD: ack_out=1. If req_s=0, set ack_out<=0 and go to IDLE. Otherwise stay.
- Latency:
  - req_in rise to ack_out rise is SYNC_STAGES+1 clk edges (3 by default) when not full.
  - req_in fall to ack_out fall is SYNC_STAGES+1 edges.
- Capture: sel_in and data_in are sampled on the push edge. The push happens only after req_s=1, which is legal under the bundled-data rule.
- Exactly one push per four-phase cycle. No new push can occur until ack has dropped and req has been seen low, then high again.
- FIFO:
  - Read and write pointers are $clog2(DEPTH)+1 bits.
  - Full when pointer MSBs differ and the low bits are equal; empty when the pointers are equal.
  - Pointers wrap naturally at DEPTH.
  - Pop when out_valid && out_ready. out_sel and out_data are combinational from the head entry (show-ahead).
  - Simultaneous push and pop when not full and not empty: both occur and fifo_count is unchanged.
  - Push and pop in the same cycle when empty: only the push occurs, and out_valid rises the next cycle (no bypass).
  - The full check uses the registered count. A pop in the same cycle does not permit a push when full; the push is taken the following cycle.
- out_ready with out_valid=0 is ignored.
- Reset mid-handshake:
  - ack_out drops immediately and the FIFO empties.
  - If req_in is still high after reset releases, it is treated as a new request and captured again.

Optional Feature:
- ARB_GRANT_CNT_EN
  - Defined: adds outputs grant_cnt0 and grant_cnt1, 16 bits each.
    - A counter increments on each push whose sel_in matches its channel.
    - Counters saturate at 0xFFFF and reset to 0.
    - They are cleared synchronously by an added input cnt_clr; if cnt_clr coincides with a push, the clear wins.
  - Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package arb_pkg holds:
  - typedef enum logic {IDLE, HOLD} sink_state_t;
  - localparam CNT_W = 16.
- One sub-module, arb_sync_fifo: parameterised DATA_W+1 wide, DEPTH deep, with push, pop, full, empty and count.
- The synchroniser and FSM stay in arb_grant_sink.

Test Plan:
- Reset, then req_in=1 with sel_in=1, data_in=8'hA5 → ack_out=1 on the 3rd clk edge; out_valid=1 with out_sel=1, out_data=8'hA5; fifo_count=1.
- After the ack, drop req_in → ack_out=0 after 3 edges; no second push; fifo_count remains 1.
- Back-to-back arbiter sequence (ch0 0x11, then ch1 0x22, out_ready=1) → two entries popped in order (0,0x11) then (1,0x22); fifo_count returns to 0.
- out_ready=0 and 4 handshakes → fifo_count=4.
  - A 5th req leaves ack_out held at 0.
  - Pulse out_ready for one cycle → ack_out rises 1 edge after the pop; fifo_count=4.
- Assert rst while in HOLD with req_in=1 → ack_out=0 and fifo_count=0 immediately.
  - After release, the request is re-captured and ack_out rises 3 edges later.
- With ARB_GRANT_CNT_EN: 3 ch0 and 2 ch1 grants → grant_cnt0=3, grant_cnt1=2.
  - cnt_clr → both 0.
  - Preload near 0xFFFF → the counter holds at 0xFFFF.
